// File: rtl/full_adder_4.sv
// Registered ripple-carry adder: a chain of full-adder cells feeding an output
// register with valid strobe and two's-complement overflow flag.

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s_c,
  output logic o_co_c
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_s_c  = w_p ^ i_c;
  assign o_co_c = (i_a & i_b) | (i_c & w_p);

endmodule

module full_adder_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  // One cell per bit; carry ripples LSB to MSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder_cell u_cell (
      .i_a    (a[gi]),
      .i_b    (b[gi]),
      .i_c    (w_carry[gi]),
      .o_s_c  (w_sum[gi]),
      .o_co_c (w_carry[gi+1])
    );
  end

  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  // Results load only with in_valid, so X/Z on idle operands never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_sum;
        r_cout <= w_carry[WIDTH];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_full_adder_4.sv
// Directed and exhaustive checks of full_adder_4: latency, hold, overflow, async reset.

module tb_full_adder_4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic       ovf;
  logic       out_valid;

  int n_vec;
  int n_err;

  full_adder_4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands on the falling edge so they are stable at the next rising edge.
  task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb_;
    cin      = tc;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    n_vec++;
    if ({s, cout, ovf, out_valid} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_async: got s=%h cout=%b ovf=%b ov=%b, want all 0", s, cout, ovf, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    settle();
    n_vec++;
    if ({s, cout, out_valid} !== {4'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_first_add: got s=%h cout=%b ov=%b, want s=0 cout=0 ov=1", s, cout, out_valid);
    end
  endtask

  task automatic test_small_sums();
    drive(1'b1, 4'd2, 4'd3, 1'b0);
    settle();
    n_vec++;
    if ({s, cout, out_valid} !== {4'd5, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL small_2p3: got s=%0d cout=%b ov=%b, want s=5 cout=0 ov=1", s, cout, out_valid);
    end
    drive(1'b1, 4'd2, 4'd3, 1'b1);
    settle();
    n_vec++;
    if ({s, cout, out_valid} !== {4'd6, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL small_2p3p1: got s=%0d cout=%b ov=%b, want s=6 cout=0 ov=1", s, cout, out_valid);
    end
  endtask

  task automatic test_full_ripple();
    drive(1'b1, 4'd8, 4'd7, 1'b0);
    settle();
    n_vec++;
    if ({s, cout, ovf} !== {4'd15, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL ripple_8p7: got s=%0d cout=%b ovf=%b, want s=15 cout=0 ovf=0", s, cout, ovf);
    end
    drive(1'b1, 4'd8, 4'd7, 1'b1);
    settle();
    n_vec++;
    if ({s, cout, ovf} !== {4'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ripple_8p7p1: got s=%0d cout=%b ovf=%b, want s=0 cout=1 ovf=0", s, cout, ovf);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 4'd7, 4'd1, 1'b0);
    settle();
    n_vec++;
    if ({s, cout, ovf} !== {4'd8, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_7p1: got s=%0d cout=%b ovf=%b, want s=8 cout=0 ovf=1", s, cout, ovf);
    end
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    settle();
    n_vec++;
    if ({s, cout, ovf} !== {4'd15, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_15p15p1: got s=%0d cout=%b ovf=%b, want s=15 cout=1 ovf=0", s, cout, ovf);
    end
    drive(1'b1, 4'd8, 4'd8, 1'b0);
    settle();
    n_vec++;
    if ({s, cout, ovf} !== {4'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_8p8: got s=%0d cout=%b ovf=%b, want s=0 cout=1 ovf=1", s, cout, ovf);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd2, 4'd3, 1'b0);
    settle();
    drive(1'b0, 4'd15, 4'd15, 1'b1);
    settle();
    n_vec++;
    if ({s, cout, ovf, out_valid} !== {4'd5, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL hold_idle: got s=%0d cout=%b ovf=%b ov=%b, want s=5 cout=0 ovf=0 ov=0", s, cout, ovf, out_valid);
    end
    drive(1'b0, 4'bxxxx, 4'bzzzz, 1'bx);
    settle();
    n_vec++;
    if ({s, cout, ovf, out_valid} !== {4'd5, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL hold_xz: got s=%b cout=%b ovf=%b ov=%b, want s=0101 cout=0 ovf=0 ov=0", s, cout, ovf, out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'd9, 4'd4, 1'b0);
    settle();
    n_vec++;
    if ({s, out_valid} !== {4'd13, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_pre: got s=%0d ov=%b, want s=13 ov=1", s, out_valid);
    end
    a = 4'd1; b = 4'd1; cin = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s, cout, ovf, out_valid} !== 7'b0) begin
      n_err++;
      $display("FAIL midrst_clear: got s=%0d cout=%b ovf=%b ov=%b, want all 0", s, cout, ovf, out_valid);
    end
    #1 rst_n = 1'b1;
    settle();
    n_vec++;
    if ({s, cout, out_valid} !== {4'd3, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_resume: got s=%0d cout=%b ov=%b, want s=3 cout=0 ov=1", s, cout, out_valid);
    end
  endtask

  task automatic test_exhaustive();
    logic [4:0] exp_sum;
    logic       exp_ovf;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          drive(1'b1, 4'(x), 4'(y), 1'(c));
          exp_sum = 5'(x) + 5'(y) + 5'(c);
          exp_ovf = (a[3] == b[3]) && (exp_sum[3] != a[3]);
          settle();
          n_vec++;
          if ({cout, s, ovf, out_valid} !== {exp_sum, exp_ovf, 1'b1}) begin
            n_err++;
            $display("FAIL exh_%0d_%0d_%0d: got cout=%b s=%0d ovf=%b ov=%b, want cout=%b s=%0d ovf=%b ov=1",
                     x, y, c, cout, s, ovf, out_valid, exp_sum[4], exp_sum[3:0], exp_ovf);
          end
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_small_sums();
    test_full_ripple();
    test_overflow();
    test_hold();
    test_async_reset();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder_4.md
# full_adder_4

Registered 4-bit ripple-carry adder: adds two unsigned 4-bit operands plus a carry-in and presents a 4-bit sum and a carry-out. The core is a chain of single-bit full-adder cells, with carry propagating LSB to MSB. The result is captured in an output register so the block drops into a synchronous datapath with a fixed one-cycle latency. It also flags two's-complement overflow and qualifies results with a valid strobe.

## Interface

Parameters:
- WIDTH, default 4, operand/sum width in bits. Must be ≥1; 4 is the production configuration.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands on a/b/cin are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- s  output  WIDTH  registered sum bits, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB cell.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  s/cout/ovf hold a result computed from operands accepted on the previous edge.

## Operation

- Bit cell i computes:
  - s_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i))
  - c_0 = cin; cout = c_WIDTH.
- Ripple structure is mandatory: one full-adder cell instance per bit, chained. No carry-lookahead, and no behavioural "+" in the core.
- Arithmetic:
  - {cout, s} equals the unsigned WIDTH+1-bit sum a + b + cin. Maximum is 2·(2^WIDTH−1)+1, so no information is lost.
  - ovf = c_WIDTH ^ c_{WIDTH−1}. It is valid only for signed interpretation; unsigned users ignore it.
- Sampling: on each rising clk edge with rst_n high:
  - If in_valid=1, s/cout/ovf load the combinational result and out_valid←1.
  - If in_valid=0, s/cout/ovf hold their previous values and out_valid←0.
- No backpressure: every valid input produces exactly one valid output one cycle later.
- X/Z on a, b, or cin while in_valid=0 must not disturb the held outputs.

## Timing

- Latency: exactly 1 clk cycle from the in_valid edge to out_valid with the corresponding result.
- Throughput: one addition per cycle; back-to-back in_valid is fully supported.
- Reset:
  - rst_n low immediately (asynchronously) forces s=0, cout=0, ovf=0, out_valid=0, with no clock required.
  - Outputs stay at these values while rst_n is low.
  - The first edge after rst_n deasserts samples normally.
- Reset mid-operation: a result captured on the edge before reset is discarded. There is no pending state to recover.
- Combinational critical path: cin → c_1 → … → c_WIDTH, i.e. WIDTH carry stages, which must close within one clk period.
- Outputs change only on a rising clk edge or on rst_n assertion. They are never combinational from the inputs.

## Test plan

- Reset: assert rst_n=0 with no clock → s=0, cout=0, ovf=0, out_valid=0 immediately. Release, then apply a=0, b=0, cin=0, in_valid=1 → next edge s=0, cout=0, out_valid=1.
- Small sums: a=2, b=3, cin=0 → s=5, cout=0. Next cycle cin=1 → s=6, cout=0. Checks one-cycle latency and back-to-back throughput.
- Full ripple: a=8, b=7, cin=0 → s=15, cout=0, ovf=0. Then cin=1 → s=0, cout=1, ovf=0, a carry rippling through all 4 bits.
- Overflow/extremes:
  - a=7, b=1, cin=0 → s=8, cout=0, ovf=1.
  - a=15, b=15, cin=1 → s=15, cout=1, ovf=0.
  - a=8, b=8, cin=0 → s=0, cout=1, ovf=1.
- Hold and valid: after a valid add of 2+3, drive in_valid=0 with a=15, b=15 → s stays 5, out_valid=0.
- Async reset mid-stream: pulse rst_n low between edges during back-to-back adds → outputs clear immediately without a clock. Exhaustive random a/b/cin with in_valid=1 must match a+b+cin, compared one cycle later.
